pe_cmd_issuer: RTL and testbench
================================

// Module: pe_cmd_issuer
// PURPOSE
//  Control-unit-side initiator for the PE command interface: takes one operation at a time from an
//  upstream request channel, drives the PE command valid/ready handshake, waits for pe_done, and
//  returns the captured result (or a timeout error) on a response channel.
//  Sits between the control unit's sequencer and the PE array interface; exactly one PE op outstanding.
// PARAMETERS
//  DATA_WIDTH      nmcu_pkg::DATA_WIDTH  operand/result width
//  TAG_WIDTH       4                     request tag width, echoed on response
//  TIMEOUT_CYCLES  64                    max WAIT-state cycles before error response (>=2)
//  CNT_WIDTH       16                    width of completed-op counter
// PORTS
//  clk             in   1                 clock
//  rst_n           in   1                 async active-low reset
//  req_valid_i     in   1                 upstream op request valid
//  req_ready_o     out  1                 issuer can accept request
//  req_cmd_i       in   instruction_t     instr_pkg::instruction_t for the op
//  req_op_a_i      in   DATA_WIDTH        operand A
//  req_op_b_i      in   DATA_WIDTH        operand B
//  req_tag_i       in   TAG_WIDTH         request tag
//  pe_cmd_valid_o  out  1                 command valid to PE interface
//  pe_cmd_o        out  instruction_t     command to PE interface
//  pe_operand_a_o  out  DATA_WIDTH        operand A to PE
//  pe_operand_b_o  out  DATA_WIDTH        operand B to PE
//  pe_cmd_ready_i  in   1                 PE interface accepts command
//  pe_done_i       in   1                 PE result valid (1-cycle pulse)
//  pe_result_i     in   DATA_WIDTH        PE result, valid while pe_done_i=1
//  rsp_valid_o     out  1                 response valid
//  rsp_ready_i     in   1                 downstream accepts response
//  rsp_result_o    out  DATA_WIDTH        captured result (0 on error)
//  rsp_tag_o       out  TAG_WIDTH         tag of the completed request
//  rsp_err_o       out  1                 1 = timeout, no pe_done seen
//  busy_o          out  1                 state != IDLE
//  op_count_o      out  CNT_WIDTH         responses delivered since reset, wraps
// BEHAVIOUR
//  - Reset: state=IDLE; all registered outputs, latched payload, timer, op_count = 0; req_ready_o=1 (IDLE).
//  - FSM IDLE->ISSUE->WAIT->RESP->IDLE. req_ready_o = (state==IDLE), combinational from state.
//  - IDLE: on req_valid_i&req_ready_o latch cmd/op_a/op_b/tag into payload regs; ->ISSUE.
//  - ISSUE: pe_cmd_valid_o=1; pe_cmd_o/pe_operand_*_o = latched payload, stable until accepted;
//    valid never drops before pe_cmd_ready_i. On pe_cmd_ready_i: ->WAIT, timer=0.
//  - WAIT: timer++ each cycle. pe_done_i=1: result_reg<=pe_result_i, err<=0, ->RESP.
//    timer==TIMEOUT_CYCLES-1 and no done: result_reg<=0, err<=1, ->RESP. Done+timeout same cycle: done wins.
//  - RESP: rsp_valid_o=1, rsp_result_o/rsp_tag_o/rsp_err_o stable. On rsp_ready_i: op_count++ (wrap), ->IDLE.
//  - pe_done_i outside WAIT is ignored (no capture, no state change). pe_cmd_valid_o=0 outside ISSUE.
//  - pe_cmd_o/pe_operand_*_o hold last latched payload outside ISSUE (don't-care for PE).
//  - Min latency, PE always ready, done 1 cycle after accept: req fire cycle 0, pe_cmd_valid cycle 1,
//    pe_done cycle 2, rsp_valid cycle 3; next req_ready_o the cycle after rsp fire.
//  - Reset asserted mid-op: op abandoned, no response, all state returns to reset values immediately.
// TESTING
//  1. Reset: rst_n low 3 cycles -> all outputs 0 except req_ready_o=1; op_count_o=0.
//  2. Single op: a=3,b=5,tag=2, PE ready=1, done next cycle w/ result 15 -> rsp_valid_o at cycle 3,
//     rsp_result_o=15, rsp_tag_o=2, rsp_err_o=0; after fire op_count_o=1, req_ready_o=1.
//  3. PE backpressure: pe_cmd_ready_i low 4 cycles -> pe_cmd_valid_o held 5 cycles, payload unchanged,
//     handshake on 5th; req_ready_o=0 throughout.
//  4. Timeout (TIMEOUT_CYCLES=8): PE accepts, never done -> RESP entered after 8 WAIT cycles,
//     rsp_err_o=1, rsp_result_o=0; done pulse at timer=7 instead -> err=0, result captured.
//  5. Resp backpressure + spurious done: rsp_ready_i low 3 cycles, pe_done_i pulsed with 99 in RESP ->
//     rsp_result_o stays 15, rsp_valid_o held, op_count_o unchanged until fire.
//  6. Reset mid-WAIT -> outputs to reset values, no response; following op a=2,b=4 completes normally.

Source files
------------

// File: rtl/pe_cmd_issuer.sv
// rtl/pe_cmd_issuer.sv - single-outstanding PE command initiator
// Accepts one request, issues it to the PE, waits for done or timeout, returns a response.
module pe_cmd_issuer #(
  parameter int DATA_WIDTH     = 32,
  parameter int CMD_WIDTH      = 32,
  parameter int TAG_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [CMD_WIDTH-1:0]  req_cmd_i,
  input  logic [DATA_WIDTH-1:0] req_op_a_i,
  input  logic [DATA_WIDTH-1:0] req_op_b_i,
  input  logic [TAG_WIDTH-1:0]  req_tag_i,
  output logic                  pe_cmd_valid_o,
  output logic [CMD_WIDTH-1:0]  pe_cmd_o,
  output logic [DATA_WIDTH-1:0] pe_operand_a_o,
  output logic [DATA_WIDTH-1:0] pe_operand_b_o,
  input  logic                  pe_cmd_ready_i,
  input  logic                  pe_done_i,
  input  logic [DATA_WIDTH-1:0] pe_result_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_result_o,
  output logic [TAG_WIDTH-1:0]  rsp_tag_o,
  output logic                  rsp_err_o,
  output logic                  busy_o,
  output logic [CNT_WIDTH-1:0]  op_count_o
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                state_q, state_d;
  logic [CMD_WIDTH-1:0]  cmd_q;
  logic [DATA_WIDTH-1:0] op_a_q, op_b_q, result_q;
  logic [TAG_WIDTH-1:0]  tag_q;
  logic                  err_q;
  logic [TW-1:0]         timer_q;
  logic [CNT_WIDTH-1:0]  count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid_i) state_d = ISSUE;
      ISSUE:   if (pe_cmd_ready_i) state_d = WAIT;
      // done and timeout in the same cycle both land in RESP; the datapath lets done win
      WAIT:    if (pe_done_i || (timer_q == TIMER_LAST)) state_d = RESP;
      RESP:    if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q    <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      tag_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      timer_q  <= '0;
      count_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            cmd_q  <= req_cmd_i;
            op_a_q <= req_op_a_i;
            op_b_q <= req_op_b_i;
            tag_q  <= req_tag_i;
          end
        end
        ISSUE: begin
          if (pe_cmd_ready_i) timer_q <= '0;
        end
        WAIT: begin
          timer_q <= timer_q + TW'(1);
          if (pe_done_i) begin
            result_q <= pe_result_i;
            err_q    <= 1'b0;
          end else if (timer_q == TIMER_LAST) begin
            result_q <= '0;
            err_q    <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready_i) count_q <= count_q + CNT_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  assign req_ready_o    = (state_q == IDLE);
  assign pe_cmd_valid_o = (state_q == ISSUE);
  assign pe_cmd_o       = cmd_q;
  assign pe_operand_a_o = op_a_q;
  assign pe_operand_b_o = op_b_q;
  assign rsp_valid_o    = (state_q == RESP);
  assign rsp_result_o   = result_q;
  assign rsp_tag_o      = tag_q;
  assign rsp_err_o      = err_q;
  assign busy_o         = (state_q != IDLE);
  assign op_count_o     = count_q;

endmodule

// File: tb/tb_pe_cmd_issuer.sv
// tb/tb_pe_cmd_issuer.sv - self-checking bench for pe_cmd_issuer
// Directed scenarios followed by randomized ops against a transaction-level model.
module tb_pe_cmd_issuer;

  localparam int DW = 16;
  localparam int CW = 8;
  localparam int TGW = 4;
  localparam int TO = 8;
  localparam int CNW = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           req_valid = 1'b0;
  logic           req_ready;
  logic [CW-1:0]  req_cmd = '0;
  logic [DW-1:0]  req_a = '0, req_b = '0;
  logic [TGW-1:0] req_tag = '0;
  logic           pe_cmd_valid;
  logic [CW-1:0]  pe_cmd;
  logic [DW-1:0]  pe_a, pe_b;
  logic           pe_cmd_ready = 1'b0;
  logic           pe_done = 1'b0;
  logic [DW-1:0]  pe_result = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [DW-1:0]  rsp_result;
  logic [TGW-1:0] rsp_tag;
  logic           rsp_err;
  logic           busy;
  logic [CNW-1:0] op_count;

  int checks = 0;
  int failures = 0;
  int model_count = 0;

  pe_cmd_issuer #(
    .DATA_WIDTH(DW), .CMD_WIDTH(CW), .TAG_WIDTH(TGW),
    .TIMEOUT_CYCLES(TO), .CNT_WIDTH(CNW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_cmd_i(req_cmd), .req_op_a_i(req_a), .req_op_b_i(req_b), .req_tag_i(req_tag),
    .pe_cmd_valid_o(pe_cmd_valid), .pe_cmd_o(pe_cmd),
    .pe_operand_a_o(pe_a), .pe_operand_b_o(pe_b),
    .pe_cmd_ready_i(pe_cmd_ready), .pe_done_i(pe_done), .pe_result_i(pe_result),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_result_o(rsp_result), .rsp_tag_o(rsp_tag), .rsp_err_o(rsp_err),
    .busy_o(busy), .op_count_o(op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_pe_cmd_valid"}, pe_cmd_valid, 0);
    chk({tag, "_pe_payload"}, {pe_cmd, pe_a, pe_b}, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_fields"}, {rsp_result, rsp_tag, rsp_err}, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_op_count"}, op_count, 0);
  endtask

  // done_at: WAIT cycle index on which done is pulsed; >= TO means the PE never answers
  task automatic run_op(input logic [CW-1:0] cmd, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [TGW-1:0] tag, input int ready_delay, input int done_at,
                        input logic [DW-1:0] res, input int rsp_delay, input bit spurious);
    int n;
    int exp_wait;
    logic [DW-1:0] exp_res;
    logic exp_err;
    exp_err  = (done_at >= TO);
    exp_res  = exp_err ? '0 : res;
    exp_wait = exp_err ? TO : done_at + 1;

    chk("idle_req_ready", req_ready, 1);
    req_valid = 1'b1; req_cmd = cmd; req_a = a; req_b = b; req_tag = tag;
    tick();
    req_valid = 1'b0;
    req_cmd = ~cmd; req_a = ~a; req_b = ~b; req_tag = ~tag;

    for (int i = 0; i <= ready_delay; i++) begin
      chk("issue_valid", pe_cmd_valid, 1);
      chk("issue_payload", {pe_cmd, pe_a, pe_b}, {cmd, a, b});
      chk("issue_req_ready", req_ready, 0);
      if (i == ready_delay) pe_cmd_ready = 1'b1;
      tick();
      pe_cmd_ready = 1'b0;
    end
    chk("post_issue_valid", pe_cmd_valid, 0);

    n = 0;
    while (!rsp_valid && n < 3 * TO) begin
      if (n == done_at) begin
        pe_done = 1'b1;
        pe_result = res;
      end
      tick();
      pe_done = 1'b0;
      pe_result = $urandom;
      n++;
    end
    chk("wait_cycles", n, exp_wait);

    for (int i = 0; i <= rsp_delay; i++) begin
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_fields", {rsp_result, rsp_tag, rsp_err}, {exp_res, tag, exp_err});
      chk("rsp_count_hold", op_count, CNW'(model_count));
      if (i == rsp_delay) rsp_ready = 1'b1;
      else if (spurious) begin
        pe_done = 1'b1;
        pe_result = 99;
      end
      tick();
      rsp_ready = 1'b0;
      pe_done = 1'b0;
    end
    model_count++;
    chk("post_rsp_count", op_count, CNW'(model_count));
    chk("post_rsp_ready", req_ready, 1);
    chk("post_rsp_valid", rsp_valid, 0);
  endtask

  initial begin
    int d;
    logic [DW-1:0] a, b;

    repeat (3) tick();
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    tick();
    chk_reset_outputs("after_release");

    // spurious done while idle must not start anything
    pe_done = 1'b1; pe_result = 16'h1234;
    tick();
    pe_done = 1'b0;
    chk("idle_done_busy", busy, 0);
    chk("idle_done_rsp", rsp_valid, 0);

    run_op(8'h11, 16'd3, 16'd5, 4'd2, 0, 0, 16'd15, 0, 0);
    run_op(8'h22, 16'd7, 16'd9, 4'd3, 4, 0, 16'd63, 0, 0);
    run_op(8'h33, 16'd1, 16'd1, 4'd4, 0, 100, 16'd55, 0, 0);
    run_op(8'h44, 16'd6, 16'd6, 4'd5, 0, TO - 1, 16'd36, 0, 0);
    run_op(8'h55, 16'd3, 16'd5, 4'd6, 1, 2, 16'd15, 3, 1);

    // reset asserted while waiting on the PE
    req_valid = 1'b1; req_cmd = 8'h66; req_a = 16'd9; req_b = 16'd9; req_tag = 4'd7;
    pe_cmd_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    pe_cmd_ready = 1'b0;
    tick();
    chk("midwait_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midwait_reset");
    model_count = 0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    pe_done = 1'b1; pe_result = 16'd81;
    tick();
    pe_done = 1'b0;
    chk("post_reset_no_rsp", rsp_valid, 0);
    run_op(8'h77, 16'd2, 16'd4, 4'd8, 0, 0, 16'd8, 0, 0);

    for (int k = 0; k < 40; k++) begin
      a = DW'($urandom_range(0, 255));
      b = DW'($urandom_range(0, 255));
      d = $urandom_range(0, TO + 3);
      run_op(CW'($urandom), a, b, TGW'($urandom), $urandom_range(0, 4), d, a * b,
             $urandom_range(0, 3), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
